rr_arbiter16: RTL and testbench

Round-robin arbiter that shares one downstream resource among 16 requesters. The requesters are the same 16 lines the priority encoder reads (ui_in[7:0] as requesters 15..8, uio_in[7:0] as requesters 7..0).
- Grants exactly one requester at a time and holds the grant until release or timeout.
- Rotates priority so that no requester starves.
- Its encoded grant index replaces the fixed-priority code on uo_out[3:0] in the top level.

---
 rtl/rr_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 36 +++
 rtl/rr_arbiter16.sv | 110 +++++++++++
 tb/tb_rr_arbiter16.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        COOL = 2'd2
    } state_t;

    // Next pointer after an owner leaves: one below it, 0 wrapping to 15.
    function automatic logic [IDX_W-1:0] dec_wrap(input logic [IDX_W-1:0] idx);
        return idx - IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search: descending from ptr with wrap-around.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_valid
);

    logic [2*N-1:0]   req_dbl;
    logic [IDX_W:0]   base;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    // rot[j] = req[(ptr+1+j) mod N], so rot[N-1] is req[ptr], rot[N-2] is req[ptr-1], ...
    // and the highest set bit of rot is the first hit of the descending search.
    assign req_dbl = {req, req};
    assign base    = {1'b0, ptr} + (IDX_W+1)'(1);
    assign rot     = req_dbl[base +: N];

    // Priority-encode the rotated vector, highest bit wins.
    always_comb begin
        off       = '0;
        win_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                off       = IDX_W'(j);
                win_valid = 1'b1;
            end
        end
    end

    assign win_idx = off + ptr + IDX_W'(1);

endmodule

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot grant, hold timeout
// and a mandatory dead cycle between owners.
//
//   state | meaning
//   IDLE  | no owner; arbitrate on each edge when ena=1
//   OWN   | grant held; ends on rel, owner dropping req, or hold timeout
//   COOL  | one dead cycle with gnt=0 before arbitrating again
module rr_arbiter16
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N-1:0]     req,
    input  logic             rel,       // owner finished ("release" is a reserved word)
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout,
    output logic             busy
);

    localparam bit             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t           state, state_nxt;
    logic [N-1:0]     gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic             timeout_nxt;
    logic [IDX_W-1:0] win_idx;
    logic             win_valid;
    logic             owner_req;
    logic             hold_done;

    rr_pick u_pick (
        .req       (req),
        .ptr       (ptr),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign owner_req = req[gnt_idx];
    assign hold_done = HOLD_EN && (hold_cnt == HOLD_LAST);

    // Next-state and next-output decode.
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        ptr_nxt     = ptr;
        cnt_nxt     = hold_cnt;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (ena && win_valid) begin
                    gnt_nxt          = '0;
                    gnt_nxt[win_idx] = 1'b1;
                    idx_nxt          = win_idx;
                    cnt_nxt          = '0;
                    state_nxt        = OWN;
                end
            end
            OWN: begin
                cnt_nxt = hold_cnt + CNT_W'(1);
                if (rel || !owner_req || hold_done) begin
                    gnt_nxt     = '0;
                    idx_nxt     = '0;
                    ptr_nxt     = dec_wrap(gnt_idx);
                    state_nxt   = COOL;
                    // Only a pure hold expiry counts as a forced revoke.
                    timeout_nxt = !rel && owner_req;
                end
            end
            COOL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            ptr      <= IDX_W'(N - 1);
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= idx_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= cnt_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign gnt_valid = |gnt;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = no owner, 1 = owned, 2 = dead cycle.
    int m_mode, m_owner, m_ptr, m_served;
    bit m_to;

    rr_arbiter16 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_ptr = 15; m_served = 0; m_to = 0;
    endtask

    // One clock edge worth of the arbitration rules, using the current inputs.
    task automatic model_step();
        bit found;
        case (m_mode)
            0: begin
                m_to = 0;
                if (ena && req != 16'd0) begin
                    found = 0;
                    for (int k = 0; k < 16; k++) begin
                        if (!found && req[(m_ptr - k + 16) % 16]) begin
                            m_owner = (m_ptr - k + 16) % 16;
                            found   = 1;
                        end
                    end
                    m_served = 0;
                    m_mode   = 1;
                end
            end
            1: begin
                m_served++;
                if (rel || !req[m_owner] || (MAX_HOLD != 0 && m_served == MAX_HOLD)) begin
                    m_to   = !rel && req[m_owner];
                    m_ptr  = (m_owner + 15) % 16;
                    m_mode = 2;
                end
            end
            default: begin
                m_mode = 0;
                m_to   = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; req = 16'd0; rel = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({gnt, gnt_idx, gnt_valid, timeout, busy} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%h idx=%0d valid=%b to=%b busy=%b, want all 0",
                     gnt, gnt_idx, gnt_valid, timeout, busy);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 16'h8001; ena = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 16'h8000 || gnt_idx !== 4'd15) begin
            n_fail++;
            $display("FAIL basic_first: gnt=%h idx=%0d, want 8000/15", gnt, gnt_idx);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        n_tests++;
        if (gnt !== 16'h0000 || busy !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_cool: gnt=%h busy=%b to=%b, want 0000/1/0", gnt, busy, timeout);
        end
        tick();
        n_tests++;
        if (gnt !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: gnt=%h busy=%b, want 0000/0", gnt, busy);
        end
        tick();
        n_tests++;
        if (gnt !== 16'h0001 || gnt_idx !== 4'd0 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_second: gnt=%h idx=%0d, want 0001/0", gnt, gnt_idx);
        end
    endtask

    task automatic test_rotation();
        int exp_idx;
        do_reset();
        req = 16'hFFFF; ena = 1'b1;
        tick();
        for (int k = 0; k < 17; k++) begin
            exp_idx = (15 - k + 16) % 16;
            n_tests++;
            if (gnt_idx !== 4'(exp_idx) || gnt !== (16'd1 << exp_idx)) begin
                n_fail++;
                $display("FAIL rotation_order[%0d]: gnt=%h idx=%0d, want idx %0d", k, gnt, gnt_idx, exp_idx);
            end
            rel = 1'b1;
            tick();
            rel = 1'b0;
            tick();
            n_tests++;
            if (gnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rotation_gap[%0d]: gnt_valid=%b, want 0", k, gnt_valid);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int  held;
        bit  done;
        bit  to_seen;
        do_reset();
        req = 16'h0020; ena = 1'b1;
        tick();
        n_tests++;
        if (gnt_idx !== 4'd5 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_grant: idx=%0d valid=%b, want 5/1", gnt_idx, gnt_valid);
        end
        held = 1; done = 0; to_seen = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (gnt_valid) held++;
            else begin
                done    = 1;
                to_seen = timeout;
            end
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout_bound: grant never revoked within 40 cycles");
        end
        n_tests++;
        if (held != MAX_HOLD) begin
            n_fail++;
            $display("FAIL timeout_hold_len: held %0d cycles, want %0d", held, MAX_HOLD);
        end
        n_tests++;
        if (to_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_pulse: timeout=%b in revoke cycle, want 1", to_seen);
        end
        tick();
        n_tests++;
        if (timeout !== 1'b0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: timeout=%b valid=%b, want 0/0", timeout, gnt_valid);
        end
        tick();
        n_tests++;
        if (gnt_idx !== 4'd5 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_regrant: idx=%0d valid=%b, want 5/1", gnt_idx, gnt_valid);
        end
        // Release landing on the expiry edge is a normal release.
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        n_tests++;
        if (gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL coincide_held: valid=%b before last cycle, want 1", gnt_valid);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        n_tests++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_release: valid=%b timeout=%b, want 0/0", gnt_valid, timeout);
        end
        req = 16'd0;
        tick();
        tick();
    endtask

    task automatic test_drop();
        do_reset();
        req = 16'h0008; ena = 1'b1;
        tick();
        n_tests++;
        if (gnt_idx !== 4'd3) begin
            n_fail++;
            $display("FAIL drop_grant: idx=%0d, want 3", gnt_idx);
        end
        req = 16'h0200;
        tick();
        n_tests++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_revoke: valid=%b timeout=%b busy=%b, want 0/0/1", gnt_valid, timeout, busy);
        end
        tick();
        tick();
        n_tests++;
        if (gnt_idx !== 4'd9 || gnt !== 16'h0200) begin
            n_fail++;
            $display("FAIL drop_next: gnt=%h idx=%0d, want 0200/9", gnt, gnt_idx);
        end
    endtask

    task automatic test_ena();
        do_reset();
        req = 16'hFFFF; ena = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (gnt !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ena_off: gnt=%h busy=%b, want 0000/0", gnt, busy);
        end
        ena = 1'b1;
        tick();
        n_tests++;
        if (gnt_idx !== 4'd15 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ena_on: idx=%0d valid=%b, want 15/1", gnt_idx, gnt_valid);
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (gnt !== 16'h8000) begin
            n_fail++;
            $display("FAIL ena_own_hold: gnt=%h, want 8000", gnt);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        n_tests++;
        if (gnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ena_release: gnt=%h, want 0000", gnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 16'h0080; ena = 1'b1;
        tick();
        n_tests++;
        if (gnt_idx !== 4'd7) begin
            n_fail++;
            $display("FAIL arst_grant: idx=%0d, want 7", gnt_idx);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (gnt !== 16'd0 || busy !== 1'b0 || gnt_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: gnt=%h busy=%b idx=%0d, want 0/0/0", gnt, busy, gnt_idx);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 16'h0081;
        tick();
        n_tests++;
        if (gnt_idx !== 4'd7 || gnt !== 16'h0080) begin
            n_fail++;
            $display("FAIL arst_ptr: gnt=%h idx=%0d, want 0080/7", gnt, gnt_idx);
        end
    endtask

    task automatic test_random();
        logic [15:0] e_gnt;
        logic [3:0]  e_idx;
        int          b;
        do_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            ena = ($urandom_range(7) != 0);
            if (cyc < 350) begin
                if ($urandom_range(3) == 0) req = 16'($urandom);
                else begin
                    b = $urandom_range(15);
                    req[b] = ~req[b];
                end
                rel = ($urandom_range(4) == 0);
            end else begin
                if ($urandom_range(19) == 0) req = 16'($urandom & $urandom);
                rel = ($urandom_range(39) == 0);
            end
            tick();
            e_gnt = (m_mode == 1) ? (16'd1 << m_owner) : 16'd0;
            e_idx = (m_mode == 1) ? 4'(m_owner) : 4'd0;
            n_tests++;
            if ({gnt, gnt_idx, gnt_valid, timeout, busy} !==
                {e_gnt, e_idx, (m_mode == 1), m_to, (m_mode != 0)}) begin
                n_fail++;
                $display("FAIL random[%0d]: got gnt=%h idx=%0d v=%b to=%b busy=%b, want gnt=%h idx=%0d v=%b to=%b busy=%b",
                         cyc, gnt, gnt_idx, gnt_valid, timeout, busy,
                         e_gnt, e_idx, (m_mode == 1), m_to, (m_mode != 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_timeout();
        test_drop();
        test_ena();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
